// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: IDLE -> ISSUE -> DONE, one access in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise requester 0 wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e              state_q, state_d;
  logic                winner_q, winner_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                busy_q, busy_d;
  logic                grant1;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q = 1 means requester 1 was granted most recently.
  logic last_q, last_d;
  assign grant1 = req1 & (~req0 | ~last_q);
`else
  assign grant1 = req1 & ~req0;
`endif

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = 1'b0;
    mem_wen_d   = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    busy_d      = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d     = StIssue;
          winner_d    = grant1;
          mem_en_d    = 1'b1;
          mem_wen_d   = grant1 ? we1 : we0;
          mem_addr_d  = grant1 ? addr1 : addr0;
          mem_wdata_d = grant1 ? wdata1 : wdata0;
          busy_d      = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_d      = grant1;
`endif
        end
      end
      StIssue: begin
        state_d = StDone;
        ack0_d  = ~winner_q;
        ack1_d  = winner_q;
        busy_d  = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      winner_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  // Memory returns data during DONE; only meaningful while an ack is high for a read.
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural single-port memory.
// Expected grant order follows ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [14:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_en, mem_wen, busy;
  logic [15:0] rdata, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [14:0] mem_addr;
  logic [15:0] mem_q [0:32767];

  int n_checks = 0;
  int n_errors = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  mem_port_arbiter #(.ADDR_W(15), .DATA_W(16)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wen) mem_q[mem_addr] <= mem_wdata;
      else         mem_rdata <= mem_q[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit port, input bit we, input logic [14:0] addr,
                       input logic [15:0] wd);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
  endtask

  // Starts at a negedge in IDLE; ends at the negedge of the following IDLE cycle.
  task automatic run_txn(input string tag, input bit port, input bit we,
                         input logic [14:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd);
    drive(port, we, addr, wd);
    @(negedge clock);
    check({tag, "_issue_en"}, 32'(mem_en), 32'd1);
    check({tag, "_issue_wen"}, 32'(mem_wen), 32'(we));
    check({tag, "_issue_addr"}, 32'(mem_addr), 32'(addr));
    if (we) check({tag, "_issue_wdata"}, 32'(mem_wdata), 32'(wd));
    check({tag, "_issue_acks"}, 32'({ack1, ack0}), 32'd0);
    check({tag, "_issue_busy"}, 32'(busy), 32'd1);
    @(negedge clock);
    check({tag, "_done_en"}, 32'({mem_en, mem_wen}), 32'd0);
    check({tag, "_done_acks"}, 32'({ack1, ack0}), port ? 32'd2 : 32'd1);
    if (!we) check({tag, "_done_rdata"}, 32'(rdata), 32'(exp_rd));
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clock);
    check({tag, "_idle_acks"}, 32'({ack1, ack0}), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_ctrl", 32'({mem_en, mem_wen, ack0, ack1, busy}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_txn("wr1", 1'b1, 1'b1, 15'h0010, 16'hBEEF, 16'h0);
    run_txn("rd0", 1'b0, 1'b0, 15'h0010, 16'h0, 16'hBEEF);
    run_txn("wr0", 1'b0, 1'b1, 15'h0123, 16'h5A3C, 16'h0);
    run_txn("rd1", 1'b1, 1'b0, 15'h0123, 16'h0, 16'h5A3C);

    // Held request re-arbitrates after exactly one idle cycle.
    drive(1'b1, 1'b0, 15'h0010, 16'h0);
    @(negedge clock);
    check("hold_issue1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check("hold_done1_ack1", 32'(ack1), 32'd1);
    @(negedge clock);
    check("hold_idle_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("hold_issue2", 32'({busy, mem_en}), 32'd3);
    @(negedge clock);
    check("hold_done2_ack1", 32'(ack1), 32'd1);
    check("hold_done2_rdata", 32'(rdata), 32'hBEEF);
    req1 = 1'b0;
    @(negedge clock);
    check("hold_end_busy", 32'(busy), 32'd0);

    // Address change while busy does not disturb the latched address.
    drive(1'b0, 1'b0, 15'h0001, 16'h0);
    @(negedge clock);
    check("chg_issue_addr", 32'(mem_addr), 32'h0001);
    addr0 = 15'h7FFF;
    we0 = 1'b1;
    @(negedge clock);
    check("chg_done_addr", 32'(mem_addr), 32'h0001);
    check("chg_done_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    @(negedge clock);
    check("chg_idle_addr", 32'(mem_addr), 32'h0001);
    run_txn("chg_next", 1'b0, 1'b1, 15'h7FFF, 16'h1234, 16'h0);

    // Reset during ISSUE aborts asynchronously with no later ack.
    drive(1'b0, 1'b0, 15'h0010, 16'h0);
    @(negedge clock);
    check("abort_issue_en", 32'(mem_en), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_async", 32'({mem_en, ack0, busy}), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    req0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort_no_ack", 32'({ack1, ack0, busy}), 32'd0);
    end

    // Both held: grant order depends on the arbitration build.
    drive(1'b0, 1'b0, 15'h0010, 16'h0);
    drive(1'b1, 1'b0, 15'h0123, 16'h0);
    for (int i = 0; i < 4; i++) begin
      bit exp1;
      exp1 = RrEn && (i % 2 == 1);
      @(negedge clock);
      check("both_issue_addr", 32'(mem_addr), exp1 ? 32'h0123 : 32'h0010);
      @(negedge clock);
      check("both_done_acks", 32'({ack1, ack0}), exp1 ? 32'd2 : 32'd1);
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clock);
      check("both_idle_busy", 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
